// File: rtl/ddc_filter_chain_scheduler_pkg.sv
// Shared definitions for the DDC filter-chain scheduler.
//   sched_state_e  : scheduler FSM encoding (RUN=0, DRAIN=1, CFG=2)
//   CHIDX_WIDTH    : width of channel indices and the round-robin pointer
//   DROP_CNT_WIDTH : width of each per-channel drop counter (optional feature)
package ddc_filter_chain_scheduler_pkg;

   localparam int CHIDX_WIDTH    = 4;
   localparam int DROP_CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CFG   = 2'd2
   } sched_state_e;

endpackage

// File: rtl/ddc_filter_chain_scheduler_rr_arbiter.sv
// ddc_rr_arbiter: combinational round-robin pick.
// Chooses the first asserted request at or after ptr, wrapping to channel 0.
//   req       in  NUM_CH        request vector
//   ptr       in  CHIDX_WIDTH   0-based starting channel
//   grant     out NUM_CH        one-hot grant
//   grant_idx out CHIDX_WIDTH   0-based index of the granted channel
//   grant_vld out 1             at least one request present
module ddc_rr_arbiter
   import ddc_filter_chain_scheduler_pkg::*;
#(
   parameter int NUM_CH = 2
) (
   input  logic [NUM_CH-1:0]      req,
   input  logic [CHIDX_WIDTH-1:0] ptr,
   output logic [NUM_CH-1:0]      grant,
   output logic [CHIDX_WIDTH-1:0] grant_idx,
   output logic                   grant_vld
);

   logic [CHIDX_WIDTH-1:0] hi_idx;
   logic [CHIDX_WIDTH-1:0] lo_idx;
   logic                   hi_vld;
   logic                   lo_vld;

   // Scan downwards so the last hit is the lowest index: lo_* is the lowest
   // request overall (wrap case), hi_* the lowest request at or after ptr.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      hi_vld = 1'b0;
      lo_vld = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (req[k]) begin
            lo_idx = CHIDX_WIDTH'(k);
            lo_vld = 1'b1;
            if (k >= int'(ptr)) begin
               hi_idx = CHIDX_WIDTH'(k);
               hi_vld = 1'b1;
            end
         end
      end
   end

   assign grant_idx = hi_vld ? hi_idx : lo_idx;
   assign grant_vld = lo_vld;

   always_comb begin
      grant = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         grant[k] = grant_vld && (grant_idx == CHIDX_WIDTH'(k));
      end
   end

endmodule

// File: rtl/ddc_filter_chain_scheduler.sv
// ddc_filter_chain_scheduler: time-multiplexes NUM_CH sample streams onto the
// shared DDC filter chain with round-robin fairness and a minimum issue gap,
// and quiesces the chain (drain + hold-off) around coefficient reconfiguration.
//
// Ports
//   CLK, nRST        clock, asynchronous active-low reset
//   Ch_Data_In       channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   Ch_Valid_In      per-channel sample strobe
//   Ch_Overflow      sticky per-channel "sample lost" flag
//   Overflow_Clr     clears Ch_Overflow (a same-cycle drop wins)
//   Cfg_Req          level request for a config window
//   Cfg_Grant        chain is quiet, config may proceed
//   Cfg_Done         pulse, config finished (only honoured in CFG)
//   Data_Out         registered sample to the filter chain
//   Data_Out_Valid   one-cycle issue strobe
//   Data_Out_ChIdx   1-based channel index of Data_Out
//   Busy             any holding register full or not in RUN
//   Ch_Drop_Cnt      (only with DDC_SCHED_DROP_CNT_EN) per-channel 16-bit
//                    saturating drop counters, cleared by Overflow_Clr
//
// Build option: define DDC_SCHED_DROP_CNT_EN to add the drop counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal issue; holding registers capture incoming samples
// DRAIN | no issue, inputs discarded; wait CHAIN_LAT cycles for chain flush
// CFG   | Cfg_Grant high, inputs discarded; leave only on Cfg_Done
module ddc_filter_chain_scheduler
   import ddc_filter_chain_scheduler_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 24,
   parameter int MIN_GAP    = 1,
   parameter int CHAIN_LAT  = 64
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic [NUM_CH*DATA_WIDTH-1:0] Ch_Data_In,
   input  logic [NUM_CH-1:0]            Ch_Valid_In,
   output logic [NUM_CH-1:0]            Ch_Overflow,
   input  logic                         Overflow_Clr,
   input  logic                         Cfg_Req,
   output logic                         Cfg_Grant,
   input  logic                         Cfg_Done,
   output logic [DATA_WIDTH-1:0]        Data_Out,
   output logic                         Data_Out_Valid,
   output logic [CHIDX_WIDTH-1:0]       Data_Out_ChIdx,
`ifdef DDC_SCHED_DROP_CNT_EN
   output logic [NUM_CH*DROP_CNT_WIDTH-1:0] Ch_Drop_Cnt,
`endif
   output logic                         Busy
);

   localparam int GAP_W   = (MIN_GAP > 0)   ? $clog2(MIN_GAP + 1)   : 1;
   localparam int DRAIN_W = (CHAIN_LAT > 0) ? $clog2(CHAIN_LAT + 1) : 1;

   sched_state_e           state_q, state_d;
   logic [DRAIN_W-1:0]     drain_q, drain_d;
   logic                   grant_q, grant_d;
   logic                   cfg_exit;

   logic [NUM_CH-1:0]      hold_full_q, hold_full_d;
   logic [DATA_WIDTH-1:0]  hold_data_q [NUM_CH];
   logic [DATA_WIDTH-1:0]  hold_data_d [NUM_CH];
   logic [NUM_CH-1:0]      ovf_q, ovf_d;
   logic [NUM_CH-1:0]      drop_set;
   logic [CHIDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [GAP_W-1:0]       gap_q, gap_d;
   logic [DATA_WIDTH-1:0]  dout_q, dout_d;
   logic                   dout_vld_q, dout_vld_d;
   logic [CHIDX_WIDTH-1:0] dout_idx_q, dout_idx_d;

   logic                   run_ok;
   logic                   issue;
   logic [NUM_CH-1:0]      arb_grant;
   logic [CHIDX_WIDTH-1:0] arb_idx;
   logic                   arb_vld;

   ddc_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req       (hold_full_q),
      .ptr       (rr_ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .grant_vld (arb_vld)
   );

   always_comb begin : fsm_next
      state_d  = state_q;
      drain_d  = drain_q;
      grant_d  = 1'b0;
      cfg_exit = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (Cfg_Req) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_W'(CHAIN_LAT);
            end
         end
         ST_DRAIN: begin
            if (!Cfg_Req) begin
               state_d = ST_RUN;
            end else if (drain_q == '0) begin
               state_d = ST_CFG;
               grant_d = 1'b1;
            end else begin
               drain_d = drain_q - DRAIN_W'(1);
            end
         end
         ST_CFG: begin
            if (Cfg_Done) begin
               state_d  = ST_RUN;
               cfg_exit = 1'b1;
            end else begin
               grant_d = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // A Cfg_Req seen in RUN blocks issue in that same cycle so nothing new
   // enters the chain once the drain has been requested.
   assign run_ok = (state_q == ST_RUN) && !Cfg_Req;
   assign issue  = run_ok && (gap_q == '0) && arb_vld;

   always_comb begin : datapath
      hold_full_d = hold_full_q;
      drop_set    = '0;
      dout_d      = dout_q;
      dout_vld_d  = 1'b0;
      dout_idx_d  = dout_idx_q;
      rr_ptr_d    = rr_ptr_q;
      gap_d       = gap_q;
      for (int k = 0; k < NUM_CH; k++) begin
         hold_data_d[k] = hold_data_q[k];
      end

      if (gap_q != '0) begin
         gap_d = gap_q - GAP_W'(1);
      end

      if (issue) begin
         dout_vld_d = 1'b1;
         dout_idx_d = arb_idx + CHIDX_WIDTH'(1);
         rr_ptr_d   = (arb_idx == CHIDX_WIDTH'(NUM_CH - 1)) ? '0 : arb_idx + CHIDX_WIDTH'(1);
         gap_d      = GAP_W'(MIN_GAP);
      end

      for (int k = 0; k < NUM_CH; k++) begin
         if (issue && arb_grant[k]) begin
            dout_d         = hold_data_q[k];
            hold_full_d[k] = 1'b0;
         end
         if (!run_ok) begin
            hold_full_d[k] = 1'b0;
         end else if (Ch_Valid_In[k]) begin
            // The slot frees up this cycle if its own channel is issued.
            if (!hold_full_q[k] || (issue && arb_grant[k])) begin
               hold_full_d[k] = 1'b1;
               hold_data_d[k] = Ch_Data_In[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               drop_set[k] = 1'b1;
            end
         end
      end

      if (cfg_exit) begin
         rr_ptr_d = '0;
         gap_d    = '0;
      end

      ovf_d = (ovf_q & ~{NUM_CH{Overflow_Clr}}) | drop_set;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_RUN;
         drain_q     <= '0;
         grant_q     <= 1'b0;
         hold_full_q <= '0;
         ovf_q       <= '0;
         rr_ptr_q    <= '0;
         gap_q       <= '0;
         dout_q      <= '0;
         dout_vld_q  <= 1'b0;
         dout_idx_q  <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            hold_data_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         grant_q     <= grant_d;
         hold_full_q <= hold_full_d;
         ovf_q       <= ovf_d;
         rr_ptr_q    <= rr_ptr_d;
         gap_q       <= gap_d;
         dout_q      <= dout_d;
         dout_vld_q  <= dout_vld_d;
         dout_idx_q  <= dout_idx_d;
         for (int k = 0; k < NUM_CH; k++) begin
            hold_data_q[k] <= hold_data_d[k];
         end
      end
   end

`ifdef DDC_SCHED_DROP_CNT_EN
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q [NUM_CH];
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_d [NUM_CH];

   // A drop in the same cycle as a clear keeps counting, matching the flag.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         drop_cnt_d[k] = drop_cnt_q[k];
         if (drop_set[k]) begin
            if (drop_cnt_q[k] != '1) begin
               drop_cnt_d[k] = drop_cnt_q[k] + DROP_CNT_WIDTH'(1);
            end
         end else if (Overflow_Clr) begin
            drop_cnt_d[k] = '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int k = 0; k < NUM_CH; k++) begin
            drop_cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            drop_cnt_q[k] <= drop_cnt_d[k];
         end
      end
   end

   always_comb begin
      Ch_Drop_Cnt = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         Ch_Drop_Cnt[k*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_cnt_q[k];
      end
   end
`endif

   assign Ch_Overflow    = ovf_q;
   assign Cfg_Grant      = grant_q;
   assign Data_Out       = dout_q;
   assign Data_Out_Valid = dout_vld_q;
   assign Data_Out_ChIdx = dout_idx_q;
   assign Busy           = (|hold_full_q) || (state_q != ST_RUN);

endmodule

// File: tb/tb_ddc_filter_chain_scheduler.sv
// Directed bench for ddc_filter_chain_scheduler (NUM_CH=2, MIN_GAP=1).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ddc_filter_chain_scheduler;

   localparam int CL = 8;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [47:0] Ch_Data_In;
   logic [1:0]  Ch_Valid_In;
   logic [1:0]  Ch_Overflow;
   logic        Overflow_Clr;
   logic        Cfg_Req;
   logic        Cfg_Grant;
   logic        Cfg_Done;
   logic [23:0] Data_Out;
   logic        Data_Out_Valid;
   logic [3:0]  Data_Out_ChIdx;
   logic        Busy;
`ifdef DDC_SCHED_DROP_CNT_EN
   logic [31:0] Ch_Drop_Cnt;
   logic [1:0]  v6;
   logic        clr6;
   logic [1:0]  ovf6;
   logic        gnt6, vld6, busy6;
   logic [23:0] dout6;
   logic [3:0]  idx6;
   logic [31:0] cnt6;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic vld_seen, gnt_seen;

   always #5 CLK = ~CLK;

   ddc_filter_chain_scheduler #(
      .NUM_CH(2), .DATA_WIDTH(24), .MIN_GAP(1), .CHAIN_LAT(CL)
   ) dut (
      .CLK(CLK), .nRST(nRST),
      .Ch_Data_In(Ch_Data_In), .Ch_Valid_In(Ch_Valid_In),
      .Ch_Overflow(Ch_Overflow), .Overflow_Clr(Overflow_Clr),
      .Cfg_Req(Cfg_Req), .Cfg_Grant(Cfg_Grant), .Cfg_Done(Cfg_Done),
      .Data_Out(Data_Out), .Data_Out_Valid(Data_Out_Valid),
      .Data_Out_ChIdx(Data_Out_ChIdx),
`ifdef DDC_SCHED_DROP_CNT_EN
      .Ch_Drop_Cnt(Ch_Drop_Cnt),
`endif
      .Busy(Busy)
   );

`ifdef DDC_SCHED_DROP_CNT_EN
   // Long gap keeps ch1 full almost all the time so nearly every cycle drops.
   ddc_filter_chain_scheduler #(
      .NUM_CH(2), .DATA_WIDTH(24), .MIN_GAP(255), .CHAIN_LAT(4)
   ) dut6 (
      .CLK(CLK), .nRST(nRST),
      .Ch_Data_In(48'h123456_654321), .Ch_Valid_In(v6),
      .Ch_Overflow(ovf6), .Overflow_Clr(clr6),
      .Cfg_Req(1'b0), .Cfg_Grant(gnt6), .Cfg_Done(1'b0),
      .Data_Out(dout6), .Data_Out_Valid(vld6), .Data_Out_ChIdx(idx6),
      .Ch_Drop_Cnt(cnt6),
      .Busy(busy6)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [23:0] d0, input logic [23:0] d1);
      Ch_Valid_In = v;
      Ch_Data_In  = {d1, d0};
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      nRST = 1'b0;
      Overflow_Clr = 1'b0;
      Cfg_Req = 1'b0;
      Cfg_Done = 1'b0;
      drive(2'b00, 24'h0, 24'h0);
`ifdef DDC_SCHED_DROP_CNT_EN
      v6 = 2'b00;
      clr6 = 1'b0;
`endif
      #12;
      chk("reset_ctrl", {23'd0, Data_Out_Valid, Data_Out_ChIdx, Ch_Overflow, Cfg_Grant, Busy}, 32'd0);
      chk("reset_data", {8'd0, Data_Out}, 32'd0);
      nRST = 1'b1;
      step();

      // Test 1: both channels at once -> ch0 at +1, ch1 at +3
      drive(2'b11, 24'h111111, 24'h222222);
      step();
      drive(2'b00, 24'h0, 24'h0);
      chk("t1_capture_novalid", {31'd0, Data_Out_Valid}, 32'd0);
      chk("t1_busy", {31'd0, Busy}, 32'd1);
      step();
      chk("t1_first", {Data_Out_Valid, Data_Out_ChIdx, Data_Out}, {1'b1, 4'd1, 24'h111111});
      step();
      chk("t1_gap", {31'd0, Data_Out_Valid}, 32'd0);
      step();
      chk("t1_second", {Data_Out_Valid, Data_Out_ChIdx, Data_Out}, {1'b1, 4'd2, 24'h222222});
      step();
      chk("t1_idle", {30'd0, Data_Out_Valid, Busy}, 32'd0);

      // Test 2: ch0 on three consecutive cycles -> third dropped
      drive(2'b01, 24'h00000A, 24'h0);
      step();
      drive(2'b01, 24'h00000B, 24'h0);
      step();
      chk("t2_issue_a", {Data_Out_Valid, Data_Out}, {1'b1, 24'h00000A});
      drive(2'b01, 24'h00000C, 24'h0);
      Overflow_Clr = 1'b1;
      step();
      drive(2'b00, 24'h0, 24'h0);
      Overflow_Clr = 1'b0;
      chk("t2_ovf_set_wins", {30'd0, Ch_Overflow}, 32'd1);
`ifdef DDC_SCHED_DROP_CNT_EN
      chk("t2_dropcnt", {16'd0, Ch_Drop_Cnt[15:0]}, 32'd1);
`endif
      step();
      chk("t2_issue_b_kept", {Data_Out_Valid, Data_Out_ChIdx, Data_Out}, {1'b1, 4'd1, 24'h00000B});
      step();
      chk("t2_ovf_sticky", {30'd0, Ch_Overflow}, 32'd1);
      Overflow_Clr = 1'b1;
      step();
      Overflow_Clr = 1'b0;
      chk("t2_ovf_clr", {30'd0, Ch_Overflow}, 32'd0);
`ifdef DDC_SCHED_DROP_CNT_EN
      chk("t2_dropcnt_clr", {16'd0, Ch_Drop_Cnt[15:0]}, 32'd0);
`endif

      // Test 3: config window with both holds full (rr pointer currently ch1)
      drive(2'b11, 24'h0A0A0A, 24'h0B0B0B);
      step();
      drive(2'b00, 24'h0, 24'h0);
      Cfg_Req = 1'b1;
      step();
      chk("t3_stop_issue", {30'd0, Data_Out_Valid, Cfg_Grant}, 32'd0);
      chk("t3_busy", {31'd0, Busy}, 32'd1);
      drive(2'b11, 24'h0C0C0C, 24'h0D0D0D);
      vld_seen = 1'b0;
      gnt_seen = 1'b0;
      repeat (CL) begin
         step();
         vld_seen |= Data_Out_Valid;
         gnt_seen |= Cfg_Grant;
      end
      chk("t3_drain_no_valid", {31'd0, vld_seen}, 32'd0);
      chk("t3_no_early_grant", {31'd0, gnt_seen}, 32'd0);
      step();
      chk("t3_grant", {31'd0, Cfg_Grant}, 32'd1);
      Cfg_Req = 1'b0;
      step();
      chk("t3_grant_holds", {31'd0, Cfg_Grant}, 32'd1);
      drive(2'b00, 24'h0, 24'h0);
      Cfg_Done = 1'b1;
      step();
      Cfg_Done = 1'b0;
      chk("t3_after_done", {29'd0, Cfg_Grant, Busy, Data_Out_Valid}, 32'd0);
      chk("t3_no_ovf", {30'd0, Ch_Overflow}, 32'd0);
      drive(2'b11, 24'h000C00, 24'h000C01);
      step();
      drive(2'b00, 24'h0, 24'h0);
      step();
      chk("t3_ch0_first", {Data_Out_Valid, Data_Out_ChIdx, Data_Out}, {1'b1, 4'd1, 24'h000C00});
      step();
      step();
      chk("t3_ch1_next", {Data_Out_Valid, Data_Out_ChIdx, Data_Out}, {1'b1, 4'd2, 24'h000C01});

      // Test 4: abort the drain after five cycles
      Cfg_Req = 1'b1;
      drive(2'b01, 24'h0D0D0D, 24'h0);
      gnt_seen = 1'b0;
      vld_seen = 1'b0;
      repeat (5) begin
         step();
         gnt_seen |= Cfg_Grant;
         vld_seen |= Data_Out_Valid;
      end
      Cfg_Req = 1'b0;
      drive(2'b00, 24'h0, 24'h0);
      step();
      gnt_seen |= Cfg_Grant;
      chk("t4_no_grant", {30'd0, gnt_seen, vld_seen}, 32'd0);
      chk("t4_back_to_run", {31'd0, Busy}, 32'd0);
      step();
      chk("t4_holds_empty", {31'd0, Data_Out_Valid}, 32'd0);
      drive(2'b10, 24'h0, 24'h0000E1);
      step();
      drive(2'b00, 24'h0, 24'h0);
      step();
      chk("t4_issue_after_abort", {Data_Out_Valid, Data_Out_ChIdx, Data_Out}, {1'b1, 4'd2, 24'h0000E1});

      // Test 5: reset while busy
      drive(2'b11, 24'h0000F0, 24'h0000F1);
      step();
      drive(2'b10, 24'h0, 24'h0000F2);
      step();
      drive(2'b00, 24'h0, 24'h0);
      chk("t5_pre_issue", {Data_Out_Valid, Data_Out_ChIdx, Ch_Overflow}, {1'b1, 4'd1, 2'b10});
      nRST = 1'b0;
      #1;
      chk("t5_reset_ctrl", {23'd0, Data_Out_Valid, Data_Out_ChIdx, Ch_Overflow, Cfg_Grant, Busy}, 32'd0);
      chk("t5_reset_data", {8'd0, Data_Out}, 32'd0);
      #1;
      nRST = 1'b1;
      step();
      step();
      chk("t5_hold_lost", {30'd0, Data_Out_Valid, Busy}, 32'd0);
      drive(2'b01, 24'h0000F3, 24'h0);
      step();
      drive(2'b00, 24'h0, 24'h0);
      step();
      chk("t5_issue_after_reset", {Data_Out_Valid, Data_Out_ChIdx, Data_Out}, {1'b1, 4'd1, 24'h0000F3});

`ifdef DDC_SCHED_DROP_CNT_EN
      // Test 6: drop counter saturation and clear
      v6 = 2'b10;
      repeat (70000) step();
      chk("t6_cnt_sat", cnt6, 32'hFFFF_0000);
      chk("t6_ovf", {30'd0, ovf6}, 32'd2);
      v6 = 2'b00;
      clr6 = 1'b1;
      step();
      clr6 = 1'b0;
      chk("t6_cnt_clr", cnt6, 32'd0);
      chk("t6_ovf_clr", {30'd0, ovf6}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
